// File: rtl/step_ramp_ctrl.sv
// Trapezoidal/triangular step-rate profile generator for motor_driver.
// Counts fed-back step edges and ramps the step divider between start and min period.
module step_ramp_ctrl #(
   parameter int SPEED_W = 64,
   parameter int COUNT_W = 32
) (
   input  logic               clk_in,
   input  logic               reset_n_in,
   input  logic               start_in,
   input  logic               abort_in,
   input  logic [COUNT_W-1:0] steps_in,
   input  logic [SPEED_W-1:0] start_period_in,
   input  logic [SPEED_W-1:0] min_period_in,
   input  logic [SPEED_W-1:0] accel_in,
   input  logic               step_fb_in,
   output logic [SPEED_W-1:0] speed_out,
   output logic               step_enable_out,
   output logic               busy_out,
   output logic               done_out,
   output logic [COUNT_W-1:0] steps_done_out,
   output logic [2:0]         state_out
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEL  = 3'd1,
      CRUISE = 3'd2,
      DECEL  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t state, state_nx;
   logic [SPEED_W-1:0] speed_nx, start_q, start_nx, min_q, min_nx, accel_q, accel_nx;
   logic [COUNT_W-1:0] cnt_nx, ramp_cnt, ramp_nx, steps_q, steps_nx;
   logic               en_nx, busy_nx, done_nx, step_fb_d;
   logic               step_edge, active;
   logic [COUNT_W-1:0] cnt_inc, rem;
   logic [SPEED_W-1:0] speed_up, speed_dn;

   // Handshake: start_in is a one-cycle request honoured only in IDLE; each rising
   // edge of step_fb_in while a move is active counts as exactly one issued step.
   assign step_edge = step_fb_in & ~step_fb_d;
   assign active    = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
   assign cnt_inc   = steps_done_out + 1'b1;
   assign rem       = steps_q - cnt_inc;
   assign state_out = state;

   // Compare before subtracting so neither direction can wrap past its limit.
   always_comb begin
      if (speed_out >= start_q || (start_q - speed_out) <= accel_q)
         speed_up = start_q;
      else
         speed_up = speed_out + accel_q;
      if (speed_out > min_q && (speed_out - min_q) > accel_q)
         speed_dn = speed_out - accel_q;
      else
         speed_dn = min_q;
   end

   always_comb begin
      state_nx = state;
      speed_nx = speed_out;
      cnt_nx   = steps_done_out;
      ramp_nx  = ramp_cnt;
      en_nx    = step_enable_out;
      busy_nx  = busy_out;
      done_nx  = 1'b0;
      steps_nx = steps_q;
      start_nx = start_q;
      min_nx   = min_q;
      accel_nx = accel_q;
      if (abort_in) begin
         state_nx = IDLE;
         en_nx    = 1'b0;
         busy_nx  = 1'b0;
         if (active && step_edge) cnt_nx = cnt_inc;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  steps_nx = steps_in;
                  start_nx = start_period_in;
                  min_nx   = min_period_in;
                  accel_nx = accel_in;
                  cnt_nx   = '0;
                  ramp_nx  = '0;
                  busy_nx  = 1'b1;
                  if (steps_in == '0) begin
                     state_nx = DONE;
                     en_nx    = 1'b0;
                  end else begin
                     speed_nx = start_period_in;
                     en_nx    = 1'b1;
                     state_nx = (min_period_in >= start_period_in) ? CRUISE : ACCEL;
                  end
               end
            end
            ACCEL, CRUISE, DECEL: begin
               if (step_edge) begin
                  cnt_nx = cnt_inc;
                  if (rem == '0) begin
                     state_nx = DONE;
                     en_nx    = 1'b0;
                  end else if (state == DECEL) begin
                     speed_nx = speed_up;
                  end else if (rem <= ramp_cnt) begin
                     state_nx = DECEL;
                     speed_nx = speed_up;
                  end else if (state == ACCEL) begin
                     speed_nx = speed_dn;
                     ramp_nx  = ramp_cnt + 1'b1;
                     if (speed_dn == min_q) state_nx = CRUISE;
                  end
               end
            end
            DONE: begin
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
            default: begin
               state_nx = IDLE;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state           <= IDLE;
         speed_out       <= '0;
         steps_done_out  <= '0;
         ramp_cnt        <= '0;
         step_fb_d       <= 1'b0;
         step_enable_out <= 1'b0;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         steps_q         <= '0;
         start_q         <= '0;
         min_q           <= '0;
         accel_q         <= '0;
      end else begin
         state           <= state_nx;
         speed_out       <= speed_nx;
         steps_done_out  <= cnt_nx;
         ramp_cnt        <= ramp_nx;
         step_fb_d       <= step_fb_in;
         step_enable_out <= en_nx;
         busy_out        <= busy_nx;
         done_out        <= done_nx;
         steps_q         <= steps_nx;
         start_q         <= start_nx;
         min_q           <= min_nx;
         accel_q         <= accel_nx;
      end
   end

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Bench for step_ramp_ctrl: a simple motor_driver model feeds steps back, a
// monitor checks per-step speed and completion against queued expectations.
module tb_step_ramp_ctrl;
   localparam int SW = 64;
   localparam int CW = 32;

   logic          clk_in = 1'b0;
   logic          reset_n_in = 1'b0;
   logic          start_in = 1'b0;
   logic          abort_in = 1'b0;
   logic [CW-1:0] steps_in = '0;
   logic [SW-1:0] start_period_in = '0;
   logic [SW-1:0] min_period_in = '0;
   logic [SW-1:0] accel_in = '0;
   logic          step_fb_in = 1'b0;
   logic [SW-1:0] speed_out;
   logic          step_enable_out;
   logic          busy_out;
   logic          done_out;
   logic [CW-1:0] steps_done_out;
   logic [2:0]    state_out;

   int checks = 0;
   int errors = 0;
   logic [SW-1:0] exp_q[$];
   logic [CW-1:0] exp_done_q[$];

   step_ramp_ctrl #(.SPEED_W(SW), .COUNT_W(CW)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .abort_in(abort_in),
      .steps_in(steps_in), .start_period_in(start_period_in), .min_period_in(min_period_in),
      .accel_in(accel_in), .step_fb_in(step_fb_in), .speed_out(speed_out),
      .step_enable_out(step_enable_out), .busy_out(busy_out), .done_out(done_out),
      .steps_done_out(steps_done_out), .state_out(state_out)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // motor_driver model: one-cycle step pulse every 4 cycles while enabled
   int ph = 0;
   always @(posedge clk_in) begin
      #2;
      if (reset_n_in && step_enable_out) begin
         ph = (ph + 1) % 4;
         step_fb_in = (ph == 3);
      end else begin
         ph = 0;
         step_fb_in = 1'b0;
      end
   end

   // monitor / scoreboard
   logic          fb_prev = 1'b0;
   logic [SW-1:0] exp_speed;
   logic [CW-1:0] exp_cnt;
   always @(negedge clk_in) begin
      if (reset_n_in) begin
         if (step_fb_in && !fb_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL step_edge unexpected step actual_speed=%0d expected=none", speed_out);
            end else begin
               exp_speed = exp_q.pop_front();
               check("step_speed", speed_out, exp_speed);
               check("step_enable_at_edge", 64'(step_enable_out), 64'd1);
            end
         end
         if (done_out) begin
            if (exp_done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_pulse unexpected actual_steps=%0d expected=no_done", steps_done_out);
            end else begin
               exp_cnt = exp_done_q.pop_front();
               check("done_steps", 64'(steps_done_out), 64'(exp_cnt));
               check("done_busy_low", 64'(busy_out), 64'd0);
            end
         end
      end
      fb_prev = step_fb_in;
   end

   // driver tasks
   task automatic start_move(input logic [CW-1:0] st, input logic [SW-1:0] sp,
                             input logic [SW-1:0] mp, input logic [SW-1:0] ac);
      @(negedge clk_in);
      steps_in = st; start_period_in = sp; min_period_in = mp; accel_in = ac;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int busy_cycles);
      busy_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy_out) break;
         busy_cycles++;
         @(negedge clk_in);
      end
      check({name, "_finish_in_budget"}, 64'(busy_out), 64'd0);
      @(negedge clk_in);
      check({name, "_done_single_pulse"}, 64'(done_out), 64'd0);
   endtask

   task automatic wait_steps(input string name, input logic [CW-1:0] target);
      for (int i = 0; i < 400; i++) begin
         if (steps_done_out == target) break;
         @(negedge clk_in);
      end
      check({name, "_reach_steps"}, 64'(steps_done_out), 64'(target));
   endtask

   task automatic push_speeds(input logic [SW-1:0] v[$]);
      foreach (v[i]) exp_q.push_back(v[i]);
   endtask

   int bc;

   initial begin
      // reset state
      repeat (3) @(negedge clk_in);
      check("reset_speed", speed_out, 64'd0);
      check("reset_enable", 64'(step_enable_out), 64'd0);
      check("reset_busy", 64'(busy_out), 64'd0);
      check("reset_done", 64'(done_out), 64'd0);
      check("reset_steps_done", 64'(steps_done_out), 64'd0);
      check("reset_state", 64'(state_out), 64'd0);
      reset_n_in = 1'b1;

      // trapezoid
      push_speeds('{100, 80, 60, 40, 40, 40, 40, 60, 80, 100});
      exp_done_q.push_back(10);
      start_move(10, 100, 40, 20);
      check("trap_busy_after_start", 64'(busy_out), 64'd1);
      check("trap_enable_after_start", 64'(step_enable_out), 64'd1);
      check("trap_initial_speed", speed_out, 64'd100);
      wait_idle("trap", bc);
      check("trap_steps_done", 64'(steps_done_out), 64'd10);
      check("trap_enable_off", 64'(step_enable_out), 64'd0);
      check("trap_speed_held", speed_out, 64'd100);

      // triangle: DECEL entered on edge 3
      push_speeds('{100, 80, 60, 80});
      exp_done_q.push_back(4);
      start_move(4, 100, 40, 20);
      wait_steps("tri", 3);
      check("tri_decel_on_edge3", 64'(state_out), 64'd3);
      wait_idle("tri", bc);
      check("tri_steps_done", 64'(steps_done_out), 64'd4);
      check("tri_speed_held", speed_out, 64'd80);

      // zero-step move
      exp_done_q.push_back(0);
      start_move(0, 100, 40, 20);
      check("zero_busy", 64'(busy_out), 64'd1);
      check("zero_no_enable", 64'(step_enable_out), 64'd0);
      wait_idle("zero", bc);
      check("zero_busy_cycles", 64'(bc), 64'd1);

      // abort at step 5, then immediate restart
      push_speeds('{100, 80, 60, 40, 40});
      start_move(10, 100, 40, 20);
      wait_steps("abort", 5);
      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
      check("abort_enable_low", 64'(step_enable_out), 64'd0);
      check("abort_busy_low", 64'(busy_out), 64'd0);
      check("abort_steps_done", 64'(steps_done_out), 64'd5);
      check("abort_state_idle", 64'(state_out), 64'd0);
      check("abort_speed_held", speed_out, 64'd40);
      push_speeds('{50, 45});
      exp_done_q.push_back(2);
      steps_in = 2; start_period_in = 50; min_period_in = 10; accel_in = 5;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      check("restart_busy", 64'(busy_out), 64'd1);
      check("restart_speed", speed_out, 64'd50);
      wait_idle("restart", bc);
      check("restart_steps_done", 64'(steps_done_out), 64'd2);

      // min above start: cruise only; mid-move start and input changes ignored
      push_speeds('{100, 100, 100});
      exp_done_q.push_back(3);
      start_move(3, 100, 120, 20);
      check("cruise_state", 64'(state_out), 64'd2);
      wait_steps("cruise", 1);
      steps_in = 7; start_period_in = 200; min_period_in = 10; accel_in = 50;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      wait_idle("cruise", bc);
      check("cruise_steps_done", 64'(steps_done_out), 64'd3);

      // zero acceleration: constant speed, decel test still terminates
      push_speeds('{100, 100, 100});
      exp_done_q.push_back(3);
      start_move(3, 100, 40, 0);
      wait_idle("accel0", bc);
      check("accel0_steps_done", 64'(steps_done_out), 64'd3);

      // asynchronous reset mid-move
      push_speeds('{100, 80, 60, 40, 40, 40, 40, 60, 80, 100});
      start_move(10, 100, 40, 20);
      wait_steps("rst", 2);
      #2;
      reset_n_in = 1'b0;
      #1;
      check("rst_speed", speed_out, 64'd0);
      check("rst_enable", 64'(step_enable_out), 64'd0);
      check("rst_busy", 64'(busy_out), 64'd0);
      check("rst_done", 64'(done_out), 64'd0);
      check("rst_steps_done", 64'(steps_done_out), 64'd0);
      check("rst_state", 64'(state_out), 64'd0);
      exp_q.delete();
      exp_done_q.delete();
      repeat (2) @(negedge clk_in);
      reset_n_in = 1'b1;
      push_speeds('{100, 80, 60, 80});
      exp_done_q.push_back(4);
      start_move(4, 100, 40, 20);
      wait_idle("post_rst", bc);
      check("post_rst_steps_done", 64'(steps_done_out), 64'd4);

      repeat (3) @(negedge clk_in);
      check("leftover_steps", 64'(exp_q.size()), 64'd0);
      check("leftover_dones", 64'(exp_done_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
